// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-sequencer state encoding.
package cpu_pkg;

    localparam int ADDR_W     = 24;
    localparam int INSTR_W    = 24;
    localparam int OPCODE_MSB = 23;
    localparam int OPCODE_LSB = 20;

    localparam logic [OPCODE_MSB-OPCODE_LSB:0] HALT_OPCODE = 4'hF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        EXEC  = 3'd3,
        HALT  = 3'd4
    } seq_state_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory request/ready bus between the sequencer and instruction memory.
interface pc_sequencer_if;
    import cpu_pkg::*;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/pc_seq_perf.sv
// Saturating retired-instruction and EXEC-stall counters for the fetch sequencer.
module pc_seq_perf (
    input  logic        Clock,
    input  logic        ResetN,
    input  logic        i_commit,
    input  logic        i_stall,
    output logic [31:0] o_retired_cnt,
    output logic [31:0] o_stall_cnt
);

    logic [31:0] r_retired_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_retired_cnt <= '0;
            r_stall_cnt   <= '0;
        end else begin
            if (i_commit && (r_retired_cnt != 32'hFFFF_FFFF))
                r_retired_cnt <= r_retired_cnt + 32'd1;
            if (i_stall && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_retired_cnt = r_retired_cnt;
    assign o_stall_cnt   = r_stall_cnt;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/sequencing controller: owns the PC, runs the imem handshake, applies stall/branch/halt.
// Counters are built only when PC_SEQ_PERF_EN is defined; otherwise they read as zero.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned       INSTR_BYTES = 3,
    parameter logic [ADDR_W-1:0] RESET_PC    = 24'h000000
) (
    input  logic                Clock,
    input  logic                ResetN,
    pc_sequencer_if.master      imem,
    input  logic                run,
    output logic [INSTR_W-1:0]  instr,
    output logic                instr_valid,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_target,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted,
    output logic [31:0]         retired_cnt,
    output logic [31:0]         stall_cnt
);

    // state | meaning
    // IDLE  | paused, waiting for run
    // FETCH | first request cycle at pc
    // WAIT  | request held until imem_ready
    // EXEC  | instr live; commits when stall is low
    // HALT  | halt opcode committed; only reset leaves

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] w_instr_nxt;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_instr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        case (r_state)
            IDLE: begin
                if (run)
                    w_state_nxt = FETCH;
            end
            FETCH, WAIT: begin
                if (imem.imem_ready) begin
                    w_instr_nxt = imem.imem_rdata;
                    w_state_nxt = EXEC;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            EXEC: begin
                if (!stall) begin
                    // Halt wins over a simultaneous branch; pc stays on the halt instruction.
                    if (is_halt(r_instr)) begin
                        w_state_nxt = HALT;
                    end else begin
                        if (branch_taken)
                            w_pc_nxt = branch_target;
                        else
                            w_pc_nxt = r_pc + ADDR_W'(INSTR_BYTES);
                        w_state_nxt = run ? FETCH : IDLE;
                    end
                end
            end
            HALT: begin
                w_state_nxt = HALT;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign imem.imem_req  = (r_state == FETCH) || (r_state == WAIT);
    assign imem.imem_addr = r_pc;
    assign instr          = r_instr;
    assign instr_valid    = (r_state == EXEC);
    assign halted         = (r_state == HALT);
    assign pc             = r_pc;

`ifdef PC_SEQ_PERF_EN
    logic w_commit;
    logic w_stall_cycle;

    assign w_commit      = (r_state == EXEC) && !stall;
    assign w_stall_cycle = (r_state == EXEC) && stall;

    pc_seq_perf u_perf (
        .Clock         (Clock),
        .ResetN        (ResetN),
        .i_commit      (w_commit),
        .i_stall       (w_stall_cycle),
        .o_retired_cnt (retired_cnt),
        .o_stall_cnt   (stall_cnt)
    );
`else
    assign retired_cnt = '0;
    assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected commits queued by the stimulus, checked by a monitor.
module tb_pc_sequencer;
    import cpu_pkg::*;

    logic               Clock = 1'b0;
    logic               ResetN = 1'b0;
    logic               run = 1'b0;
    logic               stall = 1'b0;
    logic               branch_taken = 1'b0;
    logic [ADDR_W-1:0]  branch_target = '0;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic [ADDR_W-1:0]  pc;
    logic               halted;
    logic [31:0]        retired_cnt;
    logic [31:0]        stall_cnt;

    pc_sequencer_if mif ();

    pc_sequencer dut (
        .Clock         (Clock),
        .ResetN        (ResetN),
        .imem          (mif.master),
        .run           (run),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .halted        (halted),
        .retired_cnt   (retired_cnt),
        .stall_cnt     (stall_cnt)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } exp_t;

    exp_t               exp_q[$];
    logic [INSTR_W-1:0] mem [logic [ADDR_W-1:0]];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int n_commit = 0;
    int last_commit_cyc = 0;
    int commit_gap = 0;
    int lat = 0;
    int req_cnt = 0;
    int n_req = 0;
    int ready_cyc = -1;
    logic [INSTR_W-1:0] ready_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [INSTR_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
        if (mem.exists(a)) return mem[a];
        return {4'h1, a[19:0]};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] a);
        exp_t e;
        e.pc    = a;
        e.instr = mem_rd(a);
        exp_q.push_back(e);
    endtask

    task automatic wait_commits(input int n, input int budget);
        int k;
        k = 0;
        while (n_commit < n && k < budget) begin
            tick();
            k++;
        end
        if (n_commit < n) check("commit_timeout", 32'(n_commit), 32'(n));
    endtask

    always @(posedge Clock) cyc++;

    // Memory model: ready after `lat` low cycles; outside a request it drives a
    // halt word with ready high, which the sequencer must ignore.
    always @(negedge Clock) begin
        if (mif.imem_req) begin
            if (exp_q.size() == 0) check("fetch_unexpected", 32'd1, 32'd0);
            else check("fetch_addr", 32'(mif.imem_addr), 32'(exp_q[0].pc));
            n_req++;
            if (req_cnt >= lat) begin
                mif.imem_ready = 1'b1;
                mif.imem_rdata = mem_rd(mif.imem_addr);
                ready_cyc      = cyc;
                ready_data     = mif.imem_rdata;
            end else begin
                mif.imem_ready = 1'b0;
                mif.imem_rdata = 24'hABCDEF;
            end
            req_cnt++;
        end else begin
            mif.imem_ready = 1'b1;
            mif.imem_rdata = 24'hF00000;
            req_cnt        = 0;
        end
    end

    always @(negedge Clock) begin : monitor
        exp_t e;
        if (ResetN && instr_valid && !stall) begin
            if (exp_q.size() == 0) begin
                check("commit_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("commit_pc", 32'(pc), 32'(e.pc));
                check("commit_instr", 32'(instr), 32'(e.instr));
            end
            if (n_commit > 0) commit_gap = cyc - last_commit_cyc;
            last_commit_cyc = cyc;
            n_commit++;
        end
    end

    initial begin
        mif.imem_ready = 1'b0;
        mif.imem_rdata = '0;
        mem[24'h000001] = 24'hF00000;

        #12;
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_req", 32'(mif.imem_req), 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_instr", 32'(instr), 32'h0);
        check("rst_retired", retired_cnt, 32'h0);
        check("rst_stall_cnt", stall_cnt, 32'h0);
        @(posedge Clock);
        #1 ResetN = 1'b1;

        // Three back-to-back sequential instructions, memory always ready.
        lat = 0;
        push_exp(24'h000000);
        push_exp(24'h000003);
        push_exp(24'h000006);
        run = 1'b1;
        wait_commits(2, 20);
        check("gap_2cyc_a", 32'(commit_gap), 32'd2);
        run = 1'b0;
        wait_commits(3, 20);
        check("gap_2cyc_b", 32'(commit_gap), 32'd2);
        check("seq_pc_9", 32'(pc), 32'h9);
        tick();
        check("idle_no_req", 32'(mif.imem_req), 32'h0);

        // Slow memory: three WAIT cycles with ready low.
        lat = 4;
        n_req = 0;
        push_exp(24'h000009);
        run = 1'b1;
        tick();
        run = 1'b0;
        wait_commits(4, 30);
        check("req_cycles", 32'(n_req), 32'd5);
        check("exec_after_ready", 32'(last_commit_cyc), 32'(ready_cyc + 1));
        check("instr_ready_data", 32'(instr), 32'(ready_data));
        check("wait_pc_12", 32'(pc), 32'hC);
        lat = 0;

        // Four stalled EXEC cycles, then a taken branch.
        push_exp(24'h00000C);
        stall = 1'b1;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int k = 0; k < 10 && !instr_valid; k++) tick();
        check("stall_exec", 32'(instr_valid), 32'h1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stall_pc_hold", 32'(pc), 32'hC);
            check("stall_valid", 32'(instr_valid), 32'h1);
        end
        stall = 1'b0;
        branch_taken = 1'b1;
        branch_target = 24'h000120;
        tick();
        branch_taken = 1'b0;
        check("branch_pc", 32'(pc), 32'h120);
`ifdef PC_SEQ_PERF_EN
        check("perf_stall_cnt", stall_cnt, 32'd4);
        check("perf_retired", retired_cnt, 32'(n_commit));
`endif

        // Branch to the top of the address space, then wrap on increment.
        push_exp(24'h000120);
        branch_taken = 1'b1;
        branch_target = 24'hFFFFFE;
        run = 1'b1;
        tick();
        run = 1'b0;
        wait_commits(6, 20);
        branch_taken = 1'b0;
        check("branch_top_pc", 32'(pc), 32'hFFFFFE);
        push_exp(24'hFFFFFE);
        run = 1'b1;
        tick();
        run = 1'b0;
        wait_commits(7, 20);
        check("wrap_pc", 32'(pc), 32'h000001);

        // Halt opcode beats a simultaneous branch.
        push_exp(24'h000001);
        branch_taken = 1'b1;
        branch_target = 24'h000500;
        run = 1'b1;
        wait_commits(8, 20);
        check("halt_flag", 32'(halted), 32'h1);
        check("halt_pc", 32'(pc), 32'h1);
        check("halt_valid", 32'(instr_valid), 32'h0);
        n_req = 0;
        repeat (10) tick();
        check("halt_no_req", 32'(n_req), 32'd0);
        check("halt_sticky", 32'(halted), 32'h1);
`ifdef PC_SEQ_PERF_EN
        check("perf_retired_halt", retired_cnt, 32'(n_commit));
`endif

        // Asynchronous reset in the middle of a WAIT.
        branch_taken = 1'b0;
        run = 1'b0;
        ResetN = 1'b0;
        tick();
        ResetN = 1'b1;
        check("reset_clears_halt", 32'(halted), 32'h0);
        lat = 100;
        push_exp(24'h000000);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        check("wait_req_high", 32'(mif.imem_req), 32'h1);
        ResetN = 1'b0;
        #1;
        check("async_req", 32'(mif.imem_req), 32'h0);
        check("async_pc", 32'(pc), 32'h0);
        check("async_valid", 32'(instr_valid), 32'h0);
        check("queue_drained", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        #2 ResetN = 1'b1;
        lat = 0;
        n_req = 0;
        repeat (5) tick();
        check("post_reset_idle", 32'(n_req), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch/sequencing controller for the 24-bit CPU. Owns the program counter and runs the instruction-memory request/ready handshake. Presents one instruction per commit to DataPath/ControlUnit, and applies branch redirects, stalls and halt. Replaces the free-running PC increment with an explicit FSM.

Parameters:
ADDR_W, 24, PC and instruction-memory address width
INSTR_BYTES, 3, PC increment per sequential instruction (24-bit instruction = 3 bytes)
RESET_PC, 24'h000000, PC value after reset
HALT_OPCODE, 4'hF, value of instr[23:20] that halts the sequencer

Ports:
Clock  in  1  system clock, rising edge
ResetN  in  1  asynchronous, active-low reset
run  in  1  start request; sampled only in IDLE and at commit
imem_req  out  1  instruction fetch request
imem_addr  out  ADDR_W  fetch address (= pc)
imem_ready  in  1  memory has valid data on imem_rdata this cycle
imem_rdata  in  24  fetched instruction
instr  out  24  latched current instruction, to DataPath/ControlUnit
instr_valid  out  1  instr is live this cycle (EXEC state)
stall  in  1  DataPath not ready; blocks commit
branch_taken  in  1  DataPath branch decision, sampled at commit
branch_target  in  ADDR_W  branch destination
pc  out  ADDR_W  current PC
halted  out  1  sequencer in HALT
retired_cnt  out  32  retired-instruction count (optional feature)
stall_cnt  out  32  stall cycles counted in EXEC (optional feature)

Behaviour:
- Reset (async, any state, including mid-handshake): state=IDLE, pc=RESET_PC, instr=0, imem_req=0, instr_valid=0, halted=0, counters=0.
- Outputs are registered or decoded from state only. imem_addr=pc at all times.
- IDLE: imem_req=0. If run=1, go to FETCH next cycle.
- FETCH: imem_req=1.
  - imem_ready=1 in the same cycle: instr<=imem_rdata, go to EXEC.
  - Otherwise go to WAIT.
- WAIT: imem_req=1, imem_addr held stable. Stay until imem_ready=1, then latch instr and go to EXEC.
  - No timeout. imem_ready outside FETCH/WAIT is ignored.
- EXEC: imem_req=0, instr_valid=1.
  - stall=1: hold state, pc and instr. instr_valid stays 1.
  - stall=0: commit, with the first matching case applied:
    1. instr[23:20]==HALT_OPCODE: pc unchanged, go to HALT. branch_taken is ignored.
    2. branch_taken=1: pc<=branch_target.
    3. Otherwise: pc<=pc+INSTR_BYTES modulo 2^ADDR_W (24'hFFFFFE+3 wraps to 24'h000001).
  - Non-halt commit: run=1 goes to FETCH; run=0 goes to IDLE (pause, resumes at the new pc).
- Best-case latency: 2 cycles per instruction (FETCH with ready, then EXEC). Each wait cycle adds 1.
- HALT: halted=1, imem_req=0, instr_valid=0. Exit only via ResetN.
- branch_target is used unaltered; there is no alignment check.

Optional Feature:
PC_SEQ_PERF_EN
- Defined:
  - retired_cnt increments on every commit, including the halt commit.
  - stall_cnt increments on every EXEC cycle with stall=1.
  - Both counters are 32-bit, saturate at 32'hFFFFFFFF, and clear on reset.
- Undefined: both ports are tied to 0 and no counter logic is synthesised.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W, INSTR_W=24
  - OPCODE_MSB=23, OPCODE_LSB=20
  - HALT_OPCODE
  - state enum {IDLE, FETCH, WAIT, EXEC, HALT}
- Sub-module pc_seq_perf holds the two saturating counters. It is instantiated only under PC_SEQ_PERF_EN.
- Next-PC mux and the FSM stay inline.

Test Plan:
- Reset then run=1, imem_ready always 1, three non-branch instructions:
  - pc steps 0, 3, 6, 9.
  - instr_valid high for 1 of every 2 cycles.
  - imem_addr matches pc during FETCH.
- imem_ready held low for 3 cycles in WAIT:
  - imem_req stays 1 and imem_addr stays constant.
  - EXEC entered the cycle after ready.
  - instr equals imem_rdata sampled on the ready cycle.
- EXEC with stall=1 for 4 cycles, then branch_taken=1, branch_target=24'h000120:
  - pc holds for 4 cycles, then becomes 24'h000120.
  - stall_cnt=4 and retired_cnt +1 (with PC_SEQ_PERF_EN).
- pc=24'hFFFFFE, sequential commit: pc becomes 24'h000001.
- Fetched instr=24'hF00000 with branch_taken=1:
  - HALT entered, pc unchanged, halted=1.
  - No further imem_req until ResetN pulse.
- ResetN asserted in WAIT with imem_req=1:
  - Immediately imem_req=0 and pc=RESET_PC.
  - state IDLE; no fetch until run=1 after release.
